matrix_mac_axil: RTL and testbench

MATRIX_MAC_AXIL -- requirements
Module: matrix_mac_axil

---
 rtl/matrix_mac_axil.sv | 226 ++++++++++++++++++++++
 tb/tb_matrix_mac_axil.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_axil.sv
// AXI4-Lite mapped NxN matrix multiply-accumulate engine: C = A * B, one MAC per cycle.
// Elements sit on a fixed 8x8 grid so the element index is simply address bits [7:2].
module matrix_mac_axil #(
  parameter int unsigned N  = 5,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 2*DW + $clog2(N)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [11:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        irq
);

  localparam int unsigned GRID = 64;
  localparam int unsigned PW   = 2*DW + 2;
  localparam int unsigned AW   = (CW > PW) ? CW : PW;
  localparam logic [2:0]  LAST = 3'(N - 1);
  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_RUN  = 1'b1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DW-1:0] a_mem [GRID];
  logic [DW-1:0] b_mem [GRID];
  logic [CW-1:0] c_mem [GRID];

  logic [0:0]    state_q, state_d;
  logic [2:0]    i_q, j_q, k_q, i_d, j_d, k_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          done_q, done_d, ie_q, ie_d, sgn_q, sgn_d, sgn_run_q, sgn_run_d;
  logic          c_we;

  logic          busy, wr_fire, rd_fire, start_acc;
  logic          wr_a, wr_b, wr_ctrl, wr_status, wr_err;
  logic [31:0]   rd_val;
  logic          rd_err;
  logic [CW-1:0] rd_c;
  logic [63:0]   c_wide;

  logic signed [DW:0]   a_op, b_op;
  logic signed [PW-1:0] prod;
  logic [AW-1:0]        mac_sum;
  logic                 unused_bits;

  assign unused_bits = ^{s_axi_wdata, s_axi_awaddr[1:0], s_axi_araddr[1:0], c_wide[63:32], mac_sum};

  function automatic logic el_ok(input logic [11:0] addr);
    return ({1'b0, addr[7:5]} < 4'(N)) && ({1'b0, addr[4:2]} < 4'(N));
  endfunction

  assign busy      = (state_q == S_RUN);
  assign wr_fire   = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire   = s_axi_arready & s_axi_arvalid;
  assign start_acc = wr_fire & wr_ctrl & s_axi_wdata[0] & (state_q == S_IDLE);

  // Write address decode; A/B are locked while a run is reading them
  always_comb begin
    wr_a = 1'b0; wr_b = 1'b0; wr_ctrl = 1'b0; wr_status = 1'b0; wr_err = 1'b1;
    if (s_axi_awaddr[11:10] == 2'b00) begin
      case (s_axi_awaddr[9:8])
        2'b00: if (el_ok(s_axi_awaddr) && !busy) begin wr_a = 1'b1; wr_err = 1'b0; end
        2'b01: if (el_ok(s_axi_awaddr) && !busy) begin wr_b = 1'b1; wr_err = 1'b0; end
        2'b11: begin
          if (s_axi_awaddr[7:2] == 6'd0) begin wr_ctrl = 1'b1; wr_err = 1'b0; end
          else if (s_axi_awaddr[7:2] == 6'd1) begin wr_status = 1'b1; wr_err = 1'b0; end
        end
        default: wr_err = 1'b1;
      endcase
    end
  end

  // Read decode; C is extended according to the mode of the run that produced it
  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    rd_c   = c_mem[s_axi_araddr[7:2]];
    c_wide = sgn_run_q ? 64'($signed(rd_c)) : 64'(rd_c);
    if (s_axi_araddr[11:10] == 2'b00) begin
      case (s_axi_araddr[9:8])
        2'b00: if (el_ok(s_axi_araddr)) begin rd_val = 32'(a_mem[s_axi_araddr[7:2]]); rd_err = 1'b0; end
        2'b01: if (el_ok(s_axi_araddr)) begin rd_val = 32'(b_mem[s_axi_araddr[7:2]]); rd_err = 1'b0; end
        2'b10: if (el_ok(s_axi_araddr)) begin rd_val = c_wide[31:0]; rd_err = 1'b0; end
        default: begin
          if (s_axi_araddr[7:2] == 6'd0) begin rd_val = {29'd0, ie_q, sgn_q, 1'b0}; rd_err = 1'b0; end
          else if (s_axi_araddr[7:2] == 6'd1) begin rd_val = {30'd0, done_q, busy}; rd_err = 1'b0; end
        end
      endcase
    end
  end

  // MAC datapath: operands extended by the latched mode, sum wraps at CW bits
  always_comb begin
    a_op    = $signed({sgn_run_q & a_mem[{i_q, k_q}][DW-1], a_mem[{i_q, k_q}]});
    b_op    = $signed({sgn_run_q & b_mem[{k_q, j_q}][DW-1], b_mem[{k_q, j_q}]});
    prod    = PW'(a_op) * PW'(b_op);
    mac_sum = AW'((k_q == 3'd0) ? '0 : acc_q) + AW'(prod);
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    c_we      = 1'b0;
    done_d    = done_q;
    ie_d      = ie_q;
    sgn_d     = sgn_q;
    sgn_run_d = sgn_run_q;
    if (wr_fire && wr_ctrl) begin
      ie_d  = s_axi_wdata[2];
      sgn_d = s_axi_wdata[1];
    end
    if (wr_fire && wr_status && s_axi_wdata[1]) done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d   = S_RUN;
          i_d       = 3'd0;
          j_d       = 3'd0;
          k_d       = 3'd0;
          done_d    = 1'b0;
          sgn_run_d = s_axi_wdata[1];
        end
      end
      S_RUN: begin
        acc_d = mac_sum[CW-1:0];
        k_d   = k_q + 3'd1;
        if (k_q == LAST) begin
          c_we = 1'b1;
          k_d  = 3'd0;
          j_d  = j_q + 3'd1;
          if (j_q == LAST) begin
            j_d = 3'd0;
            i_d = i_q + 3'd1;
            if (i_q == LAST) begin
              i_d     = 3'd0;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_state
    if (!resetn) begin
      state_q   <= S_IDLE;
      i_q       <= 3'd0;
      j_q       <= 3'd0;
      k_q       <= 3'd0;
      acc_q     <= '0;
      done_q    <= 1'b0;
      ie_q      <= 1'b0;
      sgn_q     <= 1'b0;
      sgn_run_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
      ie_q      <= ie_d;
      sgn_q     <= sgn_d;
      sgn_run_q <= sgn_run_d;
      irq       <= done_d & ie_d;
    end
  end

  always_ff @(posedge clk) begin : mem_write
    if (resetn && wr_fire && wr_a) a_mem[s_axi_awaddr[7:2]] <= s_axi_wdata[DW-1:0];
    if (resetn && wr_fire && wr_b) b_mem[s_axi_awaddr[7:2]] <= s_axi_wdata[DW-1:0];
    if (resetn && c_we)            c_mem[{i_q, j_q}]        <= acc_d;
  end

  // AXI handshakes: ready pulses one cycle, responses held until accepted
  always_ff @(posedge clk) begin : axi_chan
    if (!resetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
      s_axi_wready  <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      s_axi_arready <= s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        s_axi_rdata  <= rd_err ? 32'd0 : rd_val;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_mac_axil.sv
// Directed bench for matrix_mac_axil (N=5, DW=8): register map, MAC results, error
// responses, mid-run reset and B-channel back-pressure.
module tb_matrix_mac_axil;

  localparam logic [11:0] A_BASE = 12'h000;
  localparam logic [11:0] B_BASE = 12'h100;
  localparam logic [11:0] C_BASE = 12'h200;
  localparam logic [11:0] CTRL   = 12'h300;
  localparam logic [11:0] STATUS = 12'h304;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata, rdata;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = 0;

  matrix_mac_axil dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] el(input logic [11:0] base, input int i, input int j);
    return base + 12'((i * 8 + j) * 4);
  endfunction

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    if (!awready) begin
      checks++; failures++;
      $display("FAIL aw_timeout addr=%h got_awready=0 expected=1", addr);
      awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
      return;
    end
    @(posedge clk); #1;
    hs_cyc = cyc;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin
      checks++; failures++;
      $display("FAIL b_timeout addr=%h got_bvalid=0 expected=1", addr);
      resp = 2'b11;
      return;
    end
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    if (!arready) begin
      checks++; failures++;
      $display("FAIL ar_timeout addr=%h got_arready=0 expected=1", addr);
      arvalid = 1'b0; data = 32'hDEAD_BEEF; resp = 2'b11;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      checks++; failures++;
      $display("FAIL r_timeout addr=%h got_rvalid=0 expected=1", addr);
      data = 32'hDEAD_BEEF; resp = 2'b11;
      return;
    end
    data = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  // Loads A = identity, B[i][j] = i*5+j; returns the number of non-OKAY responses
  task automatic load_identity(output int errs);
    logic [1:0] r;
    errs = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        axi_write(el(A_BASE, i, j), (i == j) ? 32'd1 : 32'd0, r); if (r !== 2'b00) errs++;
        axi_write(el(B_BASE, i, j), 32'(i * 5 + j), r);          if (r !== 2'b00) errs++;
      end
  endtask

  task automatic load_const(input logic [31:0] av, input logic [31:0] bv, output int errs);
    logic [1:0] r;
    errs = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        axi_write(el(A_BASE, i, j), av, r); if (r !== 2'b00) errs++;
        axi_write(el(B_BASE, i, j), bv, r); if (r !== 2'b00) errs++;
      end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, irq, bresp, rresp, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0", {awready, wready, bvalid, arready, rvalid, irq, bresp, rresp, rdata});
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    axi_read(CTRL, d, r);
    checks++; if ({r, d} !== 34'd0) begin failures++; $display("FAIL reset_ctrl got=%h/%b expected=0/00", d, r); end
    axi_read(STATUS, d, r);
    checks++; if ({r, d} !== 34'd0) begin failures++; $display("FAIL reset_status got=%h/%b expected=0/00", d, r); end
  endtask

  task automatic test_identity();
    logic [31:0] d; logic [1:0] r; int errs; int c0; int n;
    load_identity(errs);
    checks++; if (errs !== 0) begin failures++; $display("FAIL ident_load bad_resps=%0d expected=0", errs); end
    axi_write(CTRL, 32'h5, r);
    c0 = hs_cyc;
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL ident_start resp=%b expected=00", r); end
    n = 0;
    while (!irq && n < 300) begin @(posedge clk); #1; n++; end
    checks++; if (cyc - c0 != 125) begin failures++; $display("FAIL ident_run_cycles got=%0d expected=125", cyc - c0); end
    axi_read(STATUS, d, r);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL ident_status got=%h expected=2", d); end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        axi_read(el(C_BASE, i, j), d, r);
        checks++;
        if ({r, d} !== {2'b00, 32'(i * 5 + j)}) begin
          failures++; $display("FAIL ident_c[%0d][%0d] got=%h/%b expected=%h/00", i, j, d, r, i * 5 + j);
        end
      end
    axi_read(CTRL, d, r);
    checks++; if (d !== 32'h4) begin failures++; $display("FAIL ident_ctrl_readback got=%h expected=4", d); end
    axi_write(STATUS, 32'h2, r);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ident_irq_clear got=%b expected=0", irq); end
    axi_read(STATUS, d, r);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ident_status_clear got=%h expected=0", d); end
  endtask

  task automatic test_unsigned_max();
    logic [31:0] d; logic [1:0] r; int errs; int n;
    load_const(32'hFFFF_FFFF, 32'hFFFF_FFFF, errs);
    checks++; if (errs !== 0) begin failures++; $display("FAIL umax_load bad_resps=%0d expected=0", errs); end
    axi_read(el(A_BASE, 2, 3), d, r);
    checks++; if (d !== 32'hFF) begin failures++; $display("FAIL umax_a_trunc got=%h expected=000000ff", d); end
    axi_write(CTRL, 32'h1, r);
    n = 0; d = 32'h1;
    while (d[0] && n < 80) begin axi_read(STATUS, d, r); n++; end
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL umax_status got=%h expected=2", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL umax_irq_masked got=%b expected=0", irq); end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        axi_read(el(C_BASE, i, j), d, r);
        checks++;
        if (d !== 32'h0004_F605) begin failures++; $display("FAIL umax_c[%0d][%0d] got=%h expected=0004f605", i, j, d); end
      end
  endtask

  task automatic test_signed();
    logic [31:0] d; logic [1:0] r; int errs; int n; int lost;
    load_const(32'h0000_00FF, 32'h0000_0001, errs);
    checks++; if (errs !== 0) begin failures++; $display("FAIL signed_load bad_resps=%0d expected=0", errs); end
    axi_write(CTRL, 32'h7, r);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL signed_irq_at_start got=%b expected=0", irq); end
    axi_read(STATUS, d, r);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL signed_busy_done_cleared got=%h expected=1", d); end
    n = 0;
    while (!irq && n < 300) begin @(posedge clk); #1; n++; end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL signed_irq_timeout got=%b expected=1", irq); end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        axi_read(el(C_BASE, i, j), d, r);
        checks++;
        if (d !== 32'hFFFF_FFFB) begin failures++; $display("FAIL signed_c[%0d][%0d] got=%h expected=fffffffb", i, j, d); end
      end
    lost = 0;
    repeat (5) begin @(posedge clk); #1; if (irq !== 1'b1) lost++; end
    checks++; if (lost != 0) begin failures++; $display("FAIL signed_irq_level dropped_cycles=%0d expected=0", lost); end
    axi_write(STATUS, 32'h2, r);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL signed_irq_clear got=%b expected=0", irq); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r; int n;
    axi_write(el(A_BASE, 5, 0), 32'h12, r);
    checks++; if (r !== 2'b10) begin failures++; $display("FAIL err_wr_a50 resp=%b expected=10", r); end
    axi_write(el(B_BASE, 0, 5), 32'h12, r);
    checks++; if (r !== 2'b10) begin failures++; $display("FAIL err_wr_b05 resp=%b expected=10", r); end
    axi_write(C_BASE, 32'h12, r);
    checks++; if (r !== 2'b10) begin failures++; $display("FAIL err_wr_c resp=%b expected=10", r); end
    axi_write(12'h3F0, 32'h12, r);
    checks++; if (r !== 2'b10) begin failures++; $display("FAIL err_wr_3f0 resp=%b expected=10", r); end
    axi_read(12'h3F0, d, r);
    checks++; if ({r, d} !== {2'b10, 32'd0}) begin failures++; $display("FAIL err_rd_3f0 got=%h/%b expected=0/10", d, r); end
    axi_read(el(A_BASE, 5, 0), d, r);
    checks++; if ({r, d} !== {2'b10, 32'd0}) begin failures++; $display("FAIL err_rd_a50 got=%h/%b expected=0/10", d, r); end
    axi_read(12'h400, d, r);
    checks++; if ({r, d} !== {2'b10, 32'd0}) begin failures++; $display("FAIL err_rd_400 got=%h/%b expected=0/10", d, r); end
    axi_write(CTRL, 32'h3, r);
    axi_write(el(A_BASE, 0, 0), 32'h12, r);
    checks++; if (r !== 2'b10) begin failures++; $display("FAIL err_wr_a_busy resp=%b expected=10", r); end
    axi_read(el(A_BASE, 0, 0), d, r);
    checks++; if ({r, d} !== {2'b00, 32'hFF}) begin failures++; $display("FAIL err_a_unchanged got=%h/%b expected=ff/00", d, r); end
    axi_write(CTRL, 32'h3, r);
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL err_restart_busy resp=%b expected=00", r); end
    axi_read(STATUS, d, r);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL err_status_busy got=%h expected=1", d); end
    axi_read(el(C_BASE, 4, 4), d, r);
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL err_c_read_busy resp=%b expected=00", r); end
    n = 0; d = 32'h1;
    while (d[0] && n < 80) begin axi_read(STATUS, d, r); n++; end
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL err_status_end got=%h expected=2", d); end
    axi_read(el(C_BASE, 0, 0), d, r);
    checks++; if (d !== 32'hFFFF_FFFB) begin failures++; $display("FAIL err_c00 got=%h expected=fffffffb", d); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d; logic [1:0] r; int errs; int c0; int n;
    axi_write(CTRL, 32'h5, r);
    repeat (20) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_mid_irq got=%b expected=0", irq); end
    axi_read(STATUS, d, r);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_status got=%h expected=0", d); end
    load_identity(errs);
    checks++; if (errs !== 0) begin failures++; $display("FAIL rst_mid_load bad_resps=%0d expected=0", errs); end
    axi_write(CTRL, 32'h5, r);
    c0 = hs_cyc;
    n = 0;
    while (!irq && n < 300) begin @(posedge clk); #1; n++; end
    checks++; if (cyc - c0 != 125) begin failures++; $display("FAIL rst_mid_run_cycles got=%0d expected=125", cyc - c0); end
    axi_read(el(C_BASE, 4, 4), d, r);
    checks++; if (d !== 32'd24) begin failures++; $display("FAIL rst_mid_c44 got=%h expected=18", d); end
    axi_read(el(C_BASE, 1, 3), d, r);
    checks++; if (d !== 32'd8) begin failures++; $display("FAIL rst_mid_c13 got=%h expected=8", d); end
    axi_write(STATUS, 32'h2, r);
  endtask

  task automatic test_bready_stall();
    logic [31:0] d; logic [1:0] r; int n; int not_held; int pulses;
    awaddr = el(A_BASE, 1, 1); wdata = 32'h12; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (awready !== 1'b1) begin failures++; $display("FAIL stall_first_awready got=%b expected=1", awready); end
    @(posedge clk); #1;
    awaddr = el(A_BASE, 2, 2); wdata = 32'h34;
    not_held = 0; pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bvalid !== 1'b1 || bresp !== 2'b00) not_held++;
      if (awready !== 1'b0) pulses++;
    end
    checks++; if (not_held != 0) begin failures++; $display("FAIL stall_bvalid_held bad_cycles=%0d expected=0", not_held); end
    checks++; if (pulses != 0) begin failures++; $display("FAIL stall_awready_pulses got=%0d expected=0", pulses); end
    bready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL stall_b_done got=%b expected=0", bvalid); end
    n = 0;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (awready !== 1'b1) begin failures++; $display("FAIL stall_second_awready got=%b expected=1", awready); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if ({bvalid, bresp} !== 3'b100) begin failures++; $display("FAIL stall_second_b got=%b/%b expected=1/00", bvalid, bresp); end
    @(posedge clk); #1;
    axi_read(el(A_BASE, 1, 1), d, r);
    checks++; if (d !== 32'h12) begin failures++; $display("FAIL stall_a11 got=%h expected=12", d); end
    axi_read(el(A_BASE, 2, 2), d, r);
    checks++; if (d !== 32'h34) begin failures++; $display("FAIL stall_a22 got=%h expected=34", d); end
  endtask

  initial begin
    resetn = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_identity();
    test_unsigned_max();
    test_signed();
    test_errors();
    test_reset_midrun();
    test_bready_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
